// File: rtl/tl_async_a_sink.sv
`default_nettype none
// tl_async_a_sink: slave-side end of the A-channel async queue (Gray pointer sync, registered dequeue).
// Revision 1.0
module tl_async_a_sink #(
  parameter int DEPTH  = 8,
  parameter int SYNC   = 3,
  parameter int DATA_W = 78,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic [DEPTH*DATA_W-1:0] i_async_mem,
  input  logic [AW:0]             i_async_widx,
  input  logic                    i_async_source_reset_n,
  output logic [AW:0]             o_async_ridx,
  output logic                    o_async_sink_reset_n,
  output logic                    o_deq_valid,
  input  logic                    i_deq_ready,
  output logic [DATA_W-1:0]       o_deq_bits
);

  logic [AW:0]       r_widx_sync [SYNC];
  logic [SYNC-1:0]   r_src_sync;
  logic [AW:0]       r_ridx_bin;
  logic [AW:0]       r_ridx_gray;
  logic              r_sink_reset_n;
  logic              r_deq_valid;
  logic [DATA_W-1:0] r_deq_bits;

  logic [DATA_W-1:0] w_slots [DEPTH];
  logic [AW:0]       w_widx_s;
  logic              w_source_ready;
  logic              w_fire;
  logic [AW:0]       w_p;
  logic [AW:0]       w_p_gray;
  logic              w_valid_nxt;

  for (genvar g = 0; g < DEPTH; g++) begin : g_slots
    assign w_slots[g] = i_async_mem[g*DATA_W +: DATA_W];
  end

  // Plain flop chains: nothing may sit between the stages.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < SYNC; i++) r_widx_sync[i] <= '0;
      r_src_sync <= '0;
    end else begin
      r_widx_sync[0] <= i_async_widx;
      for (int i = 1; i < SYNC; i++) r_widx_sync[i] <= r_widx_sync[i-1];
      r_src_sync <= {r_src_sync[SYNC-2:0], i_async_source_reset_n};
    end
  end

  assign w_widx_s       = r_widx_sync[SYNC-1];
  assign w_source_ready = r_src_sync[SYNC-1];
  assign w_fire         = r_deq_valid & i_deq_ready;

  // A lost source forces the pointer home, which also drops any beat on offer.
  assign w_p         = w_source_ready ? (r_ridx_bin + {{AW{1'b0}}, w_fire}) : '0;
  assign w_p_gray    = w_p ^ (w_p >> 1);
  assign w_valid_nxt = w_source_ready & (w_p_gray != w_widx_s);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_ridx_bin     <= '0;
      r_ridx_gray    <= '0;
      r_sink_reset_n <= 1'b0;
      r_deq_valid    <= 1'b0;
      r_deq_bits     <= '0;
    end else begin
      r_ridx_bin     <= w_p;
      r_ridx_gray    <= w_p_gray;
      r_sink_reset_n <= 1'b1;
      r_deq_valid    <= w_valid_nxt;
      if (w_valid_nxt) r_deq_bits <= w_slots[w_p[AW-1:0]];
    end
  end

  assign o_async_ridx         = r_ridx_gray;
  assign o_async_sink_reset_n = r_sink_reset_n;
  assign o_deq_valid          = r_deq_valid;
  assign o_deq_bits           = r_deq_bits;

endmodule
`default_nettype wire

// File: tb/tb_tl_async_a_sink.sv
`default_nettype none
// tb_tl_async_a_sink: directed vectors and sequences for the A-channel async sink.
// Revision 1.0
module tb_tl_async_a_sink;
  localparam int DEPTH  = 8;
  localparam int SYNC   = 3;
  localparam int DATA_W = 78;
  localparam int AW     = 3;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [DEPTH*DATA_W-1:0] mem;
  logic [AW:0]             widx;
  logic                    src_n;
  logic [AW:0]             ridx;
  logic                    sink_n;
  logic                    valid;
  logic                    ready;
  logic [DATA_W-1:0]       bits;

  int n_cmp = 0;
  int n_bad = 0;

  tl_async_a_sink #(.DEPTH(DEPTH), .SYNC(SYNC), .DATA_W(DATA_W)) dut (
    .i_clock                (clk),
    .i_reset                (rst),
    .i_async_mem            (mem),
    .i_async_widx           (widx),
    .i_async_source_reset_n (src_n),
    .o_async_ridx           (ridx),
    .o_async_sink_reset_n   (sink_n),
    .o_deq_valid            (valid),
    .i_deq_ready            (ready),
    .o_deq_bits             (bits)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW:0]       widx;
    logic              rdy;
    logic              exp_valid;
    logic [AW:0]       exp_ridx;
    logic [DATA_W-1:0] exp_bits;
  } vec_t;

  function automatic logic [AW:0] gray(input int unsigned v);
    logic [AW:0] b;
    b = v[AW:0];
    return b ^ (b >> 1);
  endfunction

  function automatic logic [DATA_W-1:0] slot_val(input int k);
    return {14'h3000 + 14'(k), 32'hC0DE_0000 + 32'(k), 32'h0000_00A5 + 32'(k)};
  endfunction

  function automatic logic [DATA_W-1:0] beat_val(input int k);
    return {14'h0100 + 14'(k), 32'hBEEF_0000 + 32'(k), 32'h5A00_0000 + 32'(k)};
  endfunction

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int s, input logic [DATA_W-1:0] v);
    mem[s*DATA_W +: DATA_W] = v;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    widx  = '0;
    src_n = 1'b1;
    ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < SYNC; i++) tick();
  endtask

  vec_t tbl [6];

  initial begin
    int wptr;
    int rcount;
    int cyc;

    rst = 1'b1; mem = '0; widx = '0; src_n = 1'b1; ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) set_slot(i, slot_val(i));

    // Test 1: reset state and release
    tick();
    tick();
    check("rst_valid", {77'd0, valid}, '0);
    check("rst_bits", bits, '0);
    check("rst_ridx", {74'd0, ridx}, '0);
    check("rst_sink_n", {77'd0, sink_n}, '0);
    rst = 1'b0;
    tick();
    check("rel_sink_n", {77'd0, sink_n}, 78'd1);
    check("rel_valid", {77'd0, valid}, '0);
    check("rel_src_ready_e1", {77'd0, dut.w_source_ready}, '0);
    tick();
    check("rel_src_ready_e2", {77'd0, dut.w_source_ready}, '0);
    tick();
    check("rel_src_ready_e3", {77'd0, dut.w_source_ready}, 78'd1);

    // Test 2: single beat latency and dequeue (table-driven)
    tbl[0] = '{4'h1, 1'b0, 1'b0, 4'h0, '0};
    tbl[1] = '{4'h1, 1'b0, 1'b0, 4'h0, '0};
    tbl[2] = '{4'h1, 1'b0, 1'b0, 4'h0, '0};
    tbl[3] = '{4'h1, 1'b0, 1'b1, 4'h0, slot_val(0)};
    tbl[4] = '{4'h1, 1'b1, 1'b0, 4'h1, slot_val(0)};
    tbl[5] = '{4'h1, 1'b0, 1'b0, 4'h1, slot_val(0)};
    for (int i = 0; i < 6; i++) begin
      widx  = tbl[i].widx;
      ready = tbl[i].rdy;
      tick();
      check($sformatf("vec%0d_valid", i), {77'd0, valid}, {77'd0, tbl[i].exp_valid});
      check($sformatf("vec%0d_ridx", i), {74'd0, ridx}, {74'd0, tbl[i].exp_ridx});
      check($sformatf("vec%0d_bits", i), bits, tbl[i].exp_bits);
    end

    // Test 3: eight queued beats, stall then drain
    do_reset();
    widx = gray(8);
    for (int i = 0; i < SYNC; i++) tick();
    check("full_pre_valid", {77'd0, valid}, '0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall%0d_valid", i), {77'd0, valid}, 78'd1);
      check($sformatf("stall%0d_bits", i), bits, slot_val(0));
      tick();
    end
    ready = 1'b1;
    for (int k = 1; k < DEPTH; k++) begin
      tick();
      check($sformatf("drain%0d_valid", k), {77'd0, valid}, 78'd1);
      check($sformatf("drain%0d_bits", k), bits, slot_val(k));
      check($sformatf("drain%0d_ridx", k), {74'd0, ridx}, {74'd0, gray(k)});
    end
    tick();
    check("drain_end_valid", {77'd0, valid}, '0);
    check("drain_end_ridx", {74'd0, ridx}, 78'hC);
    ready = 1'b0;

    // Test 4: stream 20 beats through the wrap
    do_reset();
    ready = 1'b1;
    wptr = 0; rcount = 0; cyc = 0;
    while (rcount < 20 && cyc < 400) begin
      check($sformatf("stream_ridx_c%0d", cyc), {74'd0, ridx}, {74'd0, gray(rcount)});
      if (rcount == 15) check("ridx_pre_wrap", {74'd0, ridx}, 78'h8);
      if (rcount == 16) check("ridx_wrap", {74'd0, ridx}, '0);
      if (valid) begin
        check($sformatf("stream_beat%0d", rcount), bits, beat_val(rcount));
        rcount++;
      end
      if (wptr < 20 && (wptr - rcount) < DEPTH) begin
        set_slot(wptr % DEPTH, beat_val(wptr));
        wptr++;
        widx = gray(wptr);
      end
      tick();
      cyc++;
    end
    check("stream_count", 78'(rcount), 78'd20);
    check("stream_end_ridx", {74'd0, ridx}, {74'd0, gray(20)});
    ready = 1'b0;

    // Test 5: source reset with beats pending, then re-arm
    do_reset();
    for (int i = 0; i < 4; i++) set_slot(i, slot_val(i));
    widx = gray(4);
    for (int i = 0; i <= SYNC; i++) tick();
    check("sr_first_valid", {77'd0, valid}, 78'd1);
    check("sr_first_bits", bits, slot_val(0));
    ready = 1'b1;
    tick();
    check("sr_fire_ridx", {74'd0, ridx}, 78'd1);
    check("sr_fire_bits", bits, slot_val(1));
    ready = 1'b0;
    src_n = 1'b0;
    for (int i = 0; i < SYNC; i++) begin
      tick();
      check($sformatf("sr_hold%0d_valid", i), {77'd0, valid}, 78'd1);
      check($sformatf("sr_hold%0d_ridx", i), {74'd0, ridx}, 78'd1);
    end
    ready = 1'b1;
    tick();
    check("sr_drop_valid", {77'd0, valid}, '0);
    check("sr_drop_ridx", {74'd0, ridx}, '0);
    check("sr_drop_bits", bits, slot_val(1));
    ready = 1'b0;
    widx = '0;
    set_slot(0, beat_val(77));
    src_n = 1'b1;
    for (int i = 0; i < SYNC; i++) tick();
    check("rearm_idle_valid", {77'd0, valid}, '0);
    widx = gray(1);
    for (int i = 0; i <= SYNC; i++) tick();
    check("rearm_valid", {77'd0, valid}, 78'd1);
    check("rearm_bits", bits, beat_val(77));
    check("rearm_ridx", {74'd0, ridx}, '0);

    // Test 6: asynchronous local reset between edges
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", {77'd0, valid}, '0);
    check("arst_bits", bits, '0);
    check("arst_ridx", {74'd0, ridx}, '0);
    check("arst_sink_n", {77'd0, sink_n}, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
